// File: rtl/mem_resp_pipe.sv
// Pipelined main-memory responder: one read or write per cycle, reads return
// their snapshot data with the word address exactly LATENCY cycles later.
module mem_resp_pipe #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 16,
  parameter int DEPTH_LOG2 = 13,
  parameter int LATENCY    = 4,
  parameter     INIT_FILE  = "none"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic [AWIDTH-1:0] resp_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("mem_resp_pipe: LATENCY must be in 1..8");
  end

  logic [DWIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rd_req;
  logic                  wr_req;
  logic                  unused_addr0;

  logic [LATENCY-1:0]    vld_p;
  logic [DWIDTH-1:0]     data_p [LATENCY];
  logic [AWIDTH-1:0]     addr_p [LATENCY];

  assign idx          = addr[DEPTH_LOG2:1];
  assign rd_req       = enable & ~wr;
  assign wr_req       = enable & wr;
  assign unused_addr0 = addr[0];

  always_ff @(posedge clk) begin
    if (wr_req) begin
      mem[idx] <= data_in;
    end
  end

  // Stage 0: sample the array at the accepting edge, then shift every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_req;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= rd_req ? mem[idx] : 'x;
    addr_p[0] <= {addr[AWIDTH-1:1], 1'b0};
    for (int i = 1; i < LATENCY; i++) begin
      data_p[i] <= data_p[i-1];
      addr_p[i] <= addr_p[i-1];
    end
  end

  // Output stage: gating by the final valid bit zeroes outputs the instant rst clears it.
  assign data_valid = vld_p[LATENCY-1];
  assign data_out   = data_valid ? data_p[LATENCY-1] : '0;
  assign resp_addr  = data_valid ? addr_p[LATENCY-1] : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && enable === 1'b1) begin
      assert (!$isunknown(wr))
        else $error("mem_resp_pipe: wr unknown on an accepted request");
    end
  end
`endif

endmodule

// File: tb/tb_mem_resp_pipe.sv
// Bench for mem_resp_pipe: three instances (LATENCY 1, 4, 8) share one request
// stream; a per-instance queue holds the response due in each cycle.
module tb_mem_resp_pipe;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] dout  [3];
  logic        dv    [3];
  logic [15:0] raddr [3];

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];
  sb_t q2[$];

  logic [15:0] model_mem [8192];
  int          cyc;
  int          n_checks;
  int          n_pass;

  mem_resp_pipe #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(dout[0]), .data_valid(dv[0]), .resp_addr(raddr[0]));

  mem_resp_pipe #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(dout[1]), .data_valid(dv[1]), .resp_addr(raddr[1]));

  mem_resp_pipe #(.LATENCY(8)) u_lat8 (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(dout[2]), .data_valid(dv[2]), .resp_addr(raddr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
  endtask

  task automatic monitor(input int k);
    sb_t e;
    bit  have;
    have = 0;
    case (k)
      0: if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); have = 1; end
    endcase
    if (have) begin
      chk($sformatf("dut%0d resp_valid", k), {15'd0, dv[k]}, 16'd1);
      chk($sformatf("dut%0d resp_data", k), dout[k], e.data);
      chk($sformatf("dut%0d resp_addr", k), raddr[k], e.addr);
    end else begin
      chk($sformatf("dut%0d idle_valid", k), {15'd0, dv[k]}, 16'd0);
      chk($sformatf("dut%0d idle_data", k), dout[k], 16'd0);
    end
  endtask

  // One cycle: drive the request, score the model, check outputs mid-cycle.
  task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    sb_t e;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    if (en && !w) begin
      e.addr = {a[15:1], 1'b0};
      e.data = model_mem[a[13:1]];
      e.due  = cyc + 1; q0.push_back(e);
      e.due  = cyc + 4; q1.push_back(e);
      e.due  = cyc + 8; q2.push_back(e);
    end
    if (en && w) model_mem[a[13:1]] = d;
    @(negedge clk);
    for (int k = 0; k < 3; k++) monitor(k);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s dut%0d valid", tag, k), {15'd0, dv[k]}, 16'd0);
      chk($sformatf("%s dut%0d data", tag, k), dout[k], 16'd0);
      chk($sformatf("%s dut%0d addr", tag, k), raddr[k], 16'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst      = 1'b0;
    enable   = 1'b0;
    wr       = 1'b0;
    addr     = '0;
    data_in  = '0;
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("reset_state");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload
    step(1'b1, 1'b1, 16'h0000, 16'h1111);
    step(1'b1, 1'b1, 16'h0002, 16'h2222);
    step(1'b1, 1'b1, 16'h0004, 16'h3333);
    step(1'b1, 1'b1, 16'h0006, 16'h4444);
    step(1'b1, 1'b1, 16'h0020, 16'hAAAA);
    idle(2);

    // Write then read-after-write
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(10);

    // Back-to-back reads
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    step(1'b1, 1'b0, 16'h0004, 16'h0000);
    step(1'b1, 1'b0, 16'h0006, 16'h0000);
    idle(10);

    // In-flight snapshot against a following write
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b1, 1'b1, 16'h0020, 16'h5555);
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(10);

    // Odd and aliased addresses
    step(1'b1, 1'b0, 16'h0011, 16'h0000);
    step(1'b1, 1'b0, 16'h4010, 16'h0000);
    step(1'b1, 1'b1, 16'h4011, 16'h1234);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(10);

    // Mixed reads, writes and bubbles
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    step(1'b0, 1'b1, 16'h0002, 16'hDEAD);
    step(1'b1, 1'b1, 16'h0006, 16'h7777);
    step(1'b1, 1'b0, 16'h0006, 16'h0000);
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(10);

    // Async reset with reads in flight
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    step(1'b1, 1'b0, 16'h0004, 16'h0000);
    enable = 1'b0;
    rst    = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    q0.delete();
    q1.delete();
    q2.delete();
    idle(2);
    rst = 1'b0;
    idle(10);

    // Array contents survive reset
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b1, 1'b0, 16'h0006, 16'h0000);
    idle(10);

    chk("drain dut0", 16'(q0.size()), 16'd0);
    chk("drain dut1", 16'(q1.size()), 16'd0);
    chk("drain dut2", 16'(q2.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
